// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage types: FSM states, the {pc, inst} packet and PC constants.
// Pure declarations, so there is no latency and no flow control here.
package if_fetch_stage_pkg;

  localparam int unsigned INST_W        = 32;
  localparam logic [31:0] DEF_RESET_PC  = 32'hBFC0_0000;
  localparam logic [31:0] DEF_PC_STEP   = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_pkt_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, inst} parking register; it is visible on the cycle after a load.
// Backpressure: none of its own. Clear beats load, and load beats unload.
module if_skid_buf
  import if_fetch_stage_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       load_i,
  input  logic       unload_i,
  input  logic       clear_i,
  input  fetch_pkt_t pkt_i,
  output logic       valid_o,
  output fetch_pkt_t pkt_o
);

  logic       valid_q, valid_d;
  fetch_pkt_t pkt_q, pkt_d;

  always_comb begin
    valid_d = valid_q;
    pkt_d   = pkt_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pkt_d   = pkt_i;
    end else if (unload_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      pkt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
    end
  end

  assign valid_o = valid_q;
  assign pkt_o   = pkt_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS fetch stage: one outstanding imem read, best case 2 cycles per instruction, registered outputs.
// Backpressure: a word that returns while decode stalls is parked in the skid buffer, and fetch pauses until it drains.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] PC_STEP  = DEF_PC_STEP
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_allowin,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         discard_q, discard_d;
  logic         out_vld_q, out_vld_d;
  fetch_pkt_t   out_pkt_q, out_pkt_d;

  fetch_pkt_t   rsp_pkt, skid_pkt;
  logic         skid_vld, skid_load, skid_unload, skid_clear;
  logic [31:0]  redir_tgt, pc_inc;

  assign rsp_pkt   = '{pc: pc_q, inst: inst_rdata};
  assign redir_tgt = align_pc(redirect_pc);
  assign pc_inc    = pc_q + PC_STEP;

  if_skid_buf u_skid (
    .clk      (clk),
    .resetn   (resetn),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .pkt_i    (rsp_pkt),
    .valid_o  (skid_vld),
    .pkt_o    (skid_pkt)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    discard_d   = discard_q;
    out_vld_d   = out_vld_q;
    out_pkt_d   = out_pkt_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;

    if (out_vld_q && id_allowin) begin
      out_vld_d = 1'b0;
    end

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (inst_addr_ok) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          state_d = S_REQ;
          if (discard_q) begin
            pc_d      = pend_pc_q;
            discard_d = 1'b0;
          end else if (!out_vld_q || id_allowin) begin
            out_vld_d = 1'b1;
            out_pkt_d = rsp_pkt;
            pc_d      = pc_inc;
          end else begin
            skid_load = 1'b1;
            pc_d      = pc_inc;
            state_d   = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (id_allowin && skid_vld) begin
          out_vld_d   = 1'b1;
          out_pkt_d   = skid_pkt;
          skid_unload = 1'b1;
          state_d     = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A redirect squashes everything younger, and the address already on the bus must not move.
    if (redirect_valid) begin
      out_vld_d   = 1'b0;
      out_pkt_d   = out_pkt_q;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_clear  = 1'b1;
      case (state_q)
        S_REQ: begin
          discard_d = 1'b1;
          pend_pc_d = redir_tgt;
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            pc_d      = redir_tgt;
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            discard_d = 1'b1;
            pend_pc_d = redir_tgt;
          end
        end
        default: begin
          pc_d    = redir_tgt;
          state_d = S_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      pend_pc_q <= RESET_PC;
      discard_q <= 1'b0;
      out_vld_q <= 1'b0;
      out_pkt_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      discard_q <= discard_d;
      out_vld_q <= out_vld_d;
      out_pkt_q <= out_pkt_d;
    end
  end

  assign inst_req  = (state_q == S_REQ);
  assign inst_addr = pc_q;
  assign id_valid  = out_vld_q;
  assign id_pc     = out_pkt_q.pc;
  assign id_inst   = out_pkt_q.inst;

endmodule
